seg7_capture_decode: RTL and testbench

- Receive-side counterpart of the team's BCD-to-seven-segment encoder.
- Taps a multiplexed, active-low seven-segment display bus: segment lines plus per-digit anode enables.
- Filters scan glitches, decodes each stable digit pattern back to BCD, and assembles a full display frame.
- Presents the frame on a valid/ready interface. Used for display loop-back self-test and for capturing display output from external boards.

---
 rtl/seg7_pkg.sv | 37 +++
 rtl/seg7_pattern_decode.sv | 35 +++
 rtl/seg7_capture_decode.sv | 188 ++++++++++++++++++
 tb/tb_seg7_capture_decode.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// ----------------------------------------------------------------------------
// seg7_pkg : segment codes, decoded digit record and filter states
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package seg7_pkg;

  // Active-low a..g codes, bit 0 = a ... bit 6 = g; shared with the encoder
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef struct packed {
    logic [3:0] bcd;
    logic       dp;
    logic       blank;
    logic       err;
  } digit_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HELD   = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/seg7_pattern_decode.sv
// ----------------------------------------------------------------------------
// seg7_pattern_decode : active-low segment pattern to BCD/dp/blank/err
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [7:0] seg,
  output digit_t     digit
);

  always_comb begin
    digit    = '0;
    digit.dp = ~seg[7];
    case (seg[6:0])
      SEG_0:     digit.bcd = 4'd0;
      SEG_1:     digit.bcd = 4'd1;
      SEG_2:     digit.bcd = 4'd2;
      SEG_3:     digit.bcd = 4'd3;
      SEG_4:     digit.bcd = 4'd4;
      SEG_5:     digit.bcd = 4'd5;
      SEG_6:     digit.bcd = 4'd6;
      SEG_7:     digit.bcd = 4'd7;
      SEG_8:     digit.bcd = 4'd8;
      SEG_9:     digit.bcd = 4'd9;
      SEG_BLANK: digit.blank = 1'b1;
      default:   digit.err = 1'b1;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/seg7_capture_decode.sv
// ----------------------------------------------------------------------------
// seg7_capture_decode : glitch-filtered capture of a multiplexed 7-seg bus
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module seg7_capture_decode
  import seg7_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int STABLE = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            seg_n,
  input  logic [DIGITS-1:0]     an_n,
  output logic [4*DIGITS-1:0]   frame_bcd,
  output logic [DIGITS-1:0]     frame_dp,
  output logic [DIGITS-1:0]     frame_blank,
  output logic [DIGITS-1:0]     frame_err,
  output logic                  frame_valid,
  input  logic                  frame_ready,
  output logic                  overrun,
  input  logic                  clr_overrun
);

  localparam logic [7:0] STABLE_C = 8'(STABLE);

  logic [7:0]        seg_m;
  logic [7:0]        s_seg;
  logic [DIGITS-1:0] an_m;
  logic [DIGITS-1:0] s_an;

  // Bus idles high, so the synchronizer resets to all ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_m <= '1;
      s_seg <= '1;
      an_m  <= '1;
      s_an  <= '1;
    end else begin
      seg_m <= seg_n;
      s_seg <= seg_m;
      an_m  <= an_n;
      s_an  <= an_m;
    end
  end

  digit_t dec;

  seg7_pattern_decode u_decode (
    .seg   (s_seg),
    .digit (dec)
  );

  state_t            state;
  state_t            state_nx;
  logic [7:0]        cnt;
  logic [7:0]        cnt_nx;
  logic [7:0]        ref_seg;
  logic [DIGITS-1:0] ref_an;
  logic              ref_ld;
  logic              wr_en;
  logic              one_low;
  logic              changed;

  assign one_low = $onehot(~s_an);
  assign changed = (s_seg != ref_seg) || (s_an != ref_an);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    ref_ld   = 1'b0;
    wr_en    = 1'b0;
    case (state)
      IDLE: begin
        if (one_low) begin
          ref_ld   = 1'b1;
          cnt_nx   = 8'd1;
          state_nx = SETTLE;
        end
      end
      SETTLE: begin
        if (changed) begin
          state_nx = IDLE;
        end else begin
          cnt_nx = cnt + 8'd1;
          if (cnt_nx >= STABLE_C) begin
            wr_en    = 1'b1;
            state_nx = HELD;
          end
        end
      end
      HELD: begin
        if (changed) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      ref_seg <= '1;
      ref_an  <= '1;
    end else begin
      cnt <= cnt_nx;
      if (ref_ld) begin
        ref_seg <= s_seg;
        ref_an  <= s_an;
      end
    end
  end

  // ref_an is one-hot low whenever a write fires, so it doubles as the slot select
  logic [DIGITS-1:0] wr_mask;
  logic [DIGITS-1:0] slot_full;
  logic              all_full;
  logic              load;

  assign wr_mask  = wr_en ? ~ref_an : '0;
  assign all_full = &slot_full;
  assign load     = all_full && (!frame_valid || frame_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_full <= '0;
    end else begin
      slot_full <= (all_full ? '0 : slot_full) | wr_mask;
    end
  end

  for (genvar i = 0; i < DIGITS; i++) begin : g_slot
    digit_t slot_q;
    digit_t frame_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        slot_q  <= '0;
        frame_q <= '0;
      end else begin
        if (load) begin
          frame_q <= slot_q;
        end
        if (wr_mask[i]) begin
          slot_q <= dec;
        end
      end
    end

    assign frame_bcd[4*i +: 4] = frame_q.bcd;
    assign frame_dp[i]         = frame_q.dp;
    assign frame_blank[i]      = frame_q.blank;
    assign frame_err[i]        = frame_q.err;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_valid <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      if (load) begin
        frame_valid <= 1'b1;
      end else if (frame_valid && frame_ready) begin
        frame_valid <= 1'b0;
      end
      // A dropped frame wins over a same-cycle clear
      if (all_full && !load) begin
        overrun <= 1'b1;
      end else if (clr_overrun) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_seg7_capture_decode.sv
// ----------------------------------------------------------------------------
// tb_seg7_capture_decode : directed vectors plus randomized bus traffic
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_seg7_capture_decode;

  localparam int DIGITS = 4;
  localparam int STABLE = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  seg_n = 8'hFF;
  logic [3:0]  an_n = 4'hF;
  logic        frame_ready = 1'b0;
  logic        clr_overrun = 1'b0;
  logic [15:0] frame_bcd;
  logic [3:0]  frame_dp;
  logic [3:0]  frame_blank;
  logic [3:0]  frame_err;
  logic        frame_valid;
  logic        overrun;

  always #5 clk = ~clk;

  seg7_capture_decode #(.DIGITS(DIGITS), .STABLE(STABLE)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .seg_n       (seg_n),
    .an_n        (an_n),
    .frame_bcd   (frame_bcd),
    .frame_dp    (frame_dp),
    .frame_blank (frame_blank),
    .frame_err   (frame_err),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .overrun     (overrun),
    .clr_overrun (clr_overrun)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int vcount = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [6:0] code_tbl [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  // returns {bcd[3:0], dp, blank, err}
  function automatic logic [6:0] ref_decode(input logic [7:0] s);
    logic [6:0] r;
    bit         found;
    r     = {4'd0, ~s[7], 2'b00};
    found = 0;
    if (s[6:0] == 7'h7F) begin
      r[1]  = 1'b1;
      found = 1;
    end
    for (int k = 0; k < 10; k++) begin
      if (code_tbl[k] == s[6:0]) begin
        r[6:3] = 4'(k);
        found  = 1;
      end
    end
    if (!found) r[0] = 1'b1;
    return r;
  endfunction

  logic [7:0] m_sy1_seg, m_sy2_seg;
  logic [3:0] m_sy1_an, m_sy2_an;
  int         m_phase;     // 0 waiting for a single digit, 1 counting, 2 already taken
  int         m_run;
  logic [7:0] m_ref_seg;
  logic [3:0] m_ref_an;
  logic [6:0] m_slot [4];
  bit         m_full [4];
  logic [6:0] m_frame [4];
  bit         m_valid;
  bit         m_ovr;

  function automatic void model_reset();
    m_sy1_seg = 8'hFF; m_sy2_seg = 8'hFF;
    m_sy1_an  = 4'hF;  m_sy2_an  = 4'hF;
    m_phase   = 0;
    m_run     = 0;
    m_ref_seg = 8'hFF;
    m_ref_an  = 4'hF;
    for (int d = 0; d < 4; d++) begin
      m_slot[d]  = '0;
      m_full[d]  = 0;
      m_frame[d] = '0;
    end
    m_valid = 0;
    m_ovr   = 0;
  endfunction

  function automatic void model_step();
    bit all, ld, diff, wr;
    int lows, which;
    if (!rst_n) begin
      model_reset();
      return;
    end
    all = 1;
    for (int d = 0; d < 4; d++) if (!m_full[d]) all = 0;
    ld = all && (!m_valid || frame_ready);
    if (ld) begin
      for (int d = 0; d < 4; d++) m_frame[d] = m_slot[d];
      m_valid = 1;
    end else if (m_valid && frame_ready) begin
      m_valid = 0;
    end
    if (all && !ld) m_ovr = 1;
    else if (clr_overrun) m_ovr = 0;
    if (all) for (int d = 0; d < 4; d++) m_full[d] = 0;

    lows  = 0;
    which = 0;
    for (int d = 0; d < 4; d++) if (!m_sy2_an[d]) begin lows++; which = d; end
    diff = (m_sy2_seg != m_ref_seg) || (m_sy2_an != m_ref_an);
    wr   = 0;
    if (m_phase == 0) begin
      if (lows == 1) begin
        m_ref_seg = m_sy2_seg;
        m_ref_an  = m_sy2_an;
        m_run     = 1;
        m_phase   = 1;
      end
    end else if (diff) begin
      m_phase = 0;
    end else if (m_phase == 1) begin
      m_run++;
      if (m_run == STABLE) begin
        wr      = 1;
        m_phase = 2;
      end
    end
    if (wr) begin
      for (int d = 0; d < 4; d++) if (!m_ref_an[d]) which = d;
      m_slot[which] = ref_decode(m_ref_seg);
      m_full[which] = 1;
    end
    m_sy2_seg = m_sy1_seg; m_sy1_seg = seg_n;
    m_sy2_an  = m_sy1_an;  m_sy1_an  = an_n;
  endfunction

  function automatic logic [29:0] model_outs();
    logic [15:0] b;
    logic [3:0]  p, bl, er;
    for (int d = 0; d < 4; d++) begin
      b[4*d +: 4] = m_frame[d][6:3];
      p[d]  = m_frame[d][2];
      bl[d] = m_frame[d][1];
      er[d] = m_frame[d][0];
    end
    return {m_valid, m_ovr, p, bl, er, b};
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input logic [7:0] s, input logic [3:0] a);
    seg_n = s;
    an_n  = a;
    @(posedge clk);
    model_step();
    @(negedge clk);
    if (frame_valid) vcount++;
    chk("cycle", {frame_valid, overrun, frame_dp, frame_blank, frame_err, frame_bcd}, model_outs());
  endtask

  task automatic idle(input int n);
    for (int c = 0; c < n; c++) cyc(8'hFF, 4'hF);
  endtask

  task automatic scan(input logic [31:0] segs, input int first, input int last, input int dwell);
    logic [3:0] a;
    for (int d = first; d <= last; d++) begin
      a    = 4'hF;
      a[d] = 1'b0;
      for (int c = 0; c < dwell; c++) cyc(segs[8*d +: 8], a);
    end
  endtask

  typedef struct {
    logic [31:0] segs;   // byte d drives digit d
    logic [15:0] bcd;
    logic [3:0]  dp;
    logic [3:0]  blank;
    logic [3:0]  err;
  } vec_t;

  vec_t vecs [4];

  initial begin
    logic [31:0] ga;
    bit          saw;
    logic [7:0]  rs;
    logic [3:0]  ra;
    int          sel, dwell;

    vecs[0] = '{32'hF9_99_F9_B0, 16'h1413, 4'b0000, 4'b0000, 4'b0000};
    vecs[1] = '{32'h80_7E_FF_C0, 16'h8000, 4'b0100, 4'b0010, 4'b0100};
    vecs[2] = '{32'h90_82_A4_40, 16'h9620, 4'b0001, 4'b0000, 4'b0000};
    vecs[3] = '{32'hC0_12_92_F8, 16'h0557, 4'b0100, 4'b0000, 4'b0000};

    model_reset();
    @(negedge clk);
    idle(3);
    chk("reset_valid", {31'd0, frame_valid}, 32'd0);
    chk("reset_bcd", {16'd0, frame_bcd}, 32'd0);
    chk("reset_ovr", {31'd0, overrun}, 32'd0);
    rst_n = 1'b1;
    idle(2);

    // table-driven full scans, consumer always ready
    frame_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      vcount = 0;
      scan(vecs[i].segs, 0, 3, 10);
      idle(3);
      chk("tbl_pulses", vcount, 32'd1);
      chk("tbl_bcd", {16'd0, frame_bcd}, {16'd0, vecs[i].bcd});
      chk("tbl_dp", {28'd0, frame_dp}, {28'd0, vecs[i].dp});
      chk("tbl_blank", {28'd0, frame_blank}, {28'd0, vecs[i].blank});
      chk("tbl_err", {28'd0, frame_err}, {28'd0, vecs[i].err});
    end

    // glitchy 3-cycle dwells on digit 2 never land; a clean 4-cycle dwell does
    ga = 32'hB0_99_A4_F9;
    vcount = 0;
    scan(ga, 0, 1, 10);
    scan(ga, 3, 3, 10);
    for (int c = 0; c < 3; c++) cyc(8'h99, 4'b1011);
    for (int g = 0; g < 3; g++) begin
      cyc(8'hFF, 4'b1011);
      for (int c = 0; c < 3; c++) cyc(8'h99, 4'b1011);
    end
    cyc(8'hFF, 4'b1011);
    idle(6);
    chk("glitch_nowrite", vcount, 32'd0);
    for (int c = 0; c < 4; c++) cyc(8'h99, 4'b1011);
    idle(6);
    chk("dwell4_pulses", vcount, 32'd1);
    chk("dwell4_bcd", {16'd0, frame_bcd}, 32'h3421);

    // stalled consumer: first frame held, second dropped
    frame_ready = 1'b0;
    scan(vecs[2].segs, 0, 3, 10);
    scan(vecs[3].segs, 0, 3, 10);
    idle(2);
    chk("hold_valid", {31'd0, frame_valid}, 32'd1);
    chk("hold_ovr", {31'd0, overrun}, 32'd1);
    chk("hold_bcd", {16'd0, frame_bcd}, 32'h9620);
    chk("hold_dp", {28'd0, frame_dp}, 32'h1);
    clr_overrun = 1'b1;
    idle(1);
    clr_overrun = 1'b0;
    chk("ovr_clear", {31'd0, overrun}, 32'd0);
    chk("ovr_clear_valid", {31'd0, frame_valid}, 32'd1);
    scan(vecs[3].segs, 0, 2, 10);
    clr_overrun = 1'b1;
    saw = 0;
    for (int c = 0; c < 10; c++) begin
      cyc(8'hC0, 4'b0111);
      if (overrun) saw = 1;
    end
    chk("ovr_set_priority", {31'd0, saw}, 32'd1);
    idle(1);
    clr_overrun = 1'b0;
    chk("ovr_cleared_again", {31'd0, overrun}, 32'd0);
    frame_ready = 1'b1;
    idle(1);
    chk("valid_drop", {31'd0, frame_valid}, 32'd0);

    // multi-low enables never write; reset mid-settle discards partial slots
    frame_ready = 1'b0;
    scan(vecs[0].segs, 0, 3, 10);
    scan(vecs[1].segs, 0, 2, 10);
    for (int c = 0; c < 20; c++) cyc(8'h80, 4'b0011);
    chk("multilow_valid", {31'd0, frame_valid}, 32'd1);
    chk("multilow_ovr", {31'd0, overrun}, 32'd0);
    chk("multilow_bcd", {16'd0, frame_bcd}, 32'h1413);
    for (int c = 0; c < 4; c++) cyc(8'h80, 4'b0111);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rstmid_valid", {31'd0, frame_valid}, 32'd0);
    chk("rstmid_bcd", {16'd0, frame_bcd}, 32'd0);
    @(negedge clk);
    idle(2);
    rst_n = 1'b1;
    frame_ready = 1'b1;
    vcount = 0;
    scan(vecs[1].segs, 3, 3, 10);
    idle(5);
    chk("partial_discard", vcount, 32'd0);
    scan(vecs[1].segs, 0, 3, 10);
    idle(3);
    chk("after_rst_pulses", vcount, 32'd1);
    chk("after_rst_bcd", {16'd0, frame_bcd}, 32'h8000);
    chk("after_rst_blank", {28'd0, frame_blank}, 32'h2);
    chk("after_rst_err", {28'd0, frame_err}, 32'h4);

    // randomized traffic against the model
    for (int k = 0; k < 300; k++) begin
      sel = $urandom_range(0, 13);
      if (sel < 10) rs = {1'($urandom_range(0, 1)), code_tbl[sel]};
      else if (sel == 10) rs = {1'($urandom_range(0, 1)), 7'h7F};
      else rs = 8'($urandom);
      sel = $urandom_range(0, 9);
      if (sel < 7) begin
        ra = 4'hF;
        ra[$urandom_range(0, 3)] = 1'b0;
      end else if (sel == 7) begin
        ra = 4'hF;
      end else begin
        ra = 4'($urandom);
      end
      dwell = $urandom_range(1, 12);
      frame_ready = ($urandom_range(0, 3) != 0);
      for (int c = 0; c < dwell; c++) begin
        clr_overrun = ($urandom_range(0, 7) == 0);
        cyc(rs, ra);
      end
    end
    clr_overrun = 1'b0;
    idle(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
